bit_register: RTL and testbench

One-bit storage element with synchronous load enable: the `Bit` cell of the memory hierarchy. It holds a single binary value indefinitely and replaces it with the input only on a clock edge where load is asserted. It is the leaf primitive from which the 16-bit `Register`, RAM banks and the program counter are built. It has no combinational path from `in` to `out`.

---
 rtl/bit_register_if.sv | 19 +
 rtl/bit_register.sv | 30 +++
 tb/tb_bit_register.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/bit_register_if.sv
// Data/enable/output bundle for a one-bit storage cell.
// The master drives the data and the load enable; the cell returns its stored value.
interface bit_register_if;
   logic in;
   logic load;
   logic out;

   modport master (
      output in,
      output load,
      input  out
   );

   modport slave (
      input  in,
      input  load,
      output out
   );
endinterface

// File: rtl/bit_register.sv
// One-bit storage cell with a synchronous load enable.
// It is the leaf primitive underneath registers, RAM banks and the program counter.
module bit_register (
   input  logic          clk,
   input  logic          rst_n,
   bit_register_if.slave bus
);

   logic q_q;
   logic q_d;

   always_comb begin
      q_d = q_q;
      if (bus.load) begin
         q_d = bus.in;
      end
   end

   // Reset clears the cell at once, so a load that is waiting when reset arrives is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign bus.out = q_q;

endmodule

// File: tb/tb_bit_register.sv
// Self-checking bench for bit_register.
// Expected values go into a queue at each rising edge and are compared at the next falling edge.
module tb_bit_register;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic expModel;
   logic scoreboard[$];
   logic expV;

   bit_register_if bus ();

   bit_register dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one cycle of stimulus, updates the model at the rising edge and pushes the expected output.
   task automatic drive_cycle(input logic inV, input logic loadV);
      bus.in   = inV;
      bus.load = loadV;
      @(posedge clk);
      if (!rst_n) begin
         expModel = 1'b0;
      end else if (loadV) begin
         expModel = inV;
      end
      scoreboard.push_back(expModel);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      bus.in   = 1'b1;
      bus.load = 1'b1;
      expModel = 1'b0;
      #1;
      checks++;
      if (bus.out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_initial out=%b expected=0", bus.out);
      end
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b1, 1'b1);
         expV = scoreboard.pop_front();
         checks++;
         if (bus.out !== expV) begin
            errors++;
            $display("[TB] FAIL reset_hold[%0d] out=%b expected=%b", i, bus.out, expV);
         end
      end
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive_cycle(1'b1, 1'b0);
         expV = scoreboard.pop_front();
         checks++;
         if (bus.out !== expV) begin
            errors++;
            $display("[TB] FAIL reset_release[%0d] out=%b expected=%b", i, bus.out, expV);
         end
      end
   endtask

   task automatic test_load_hold();
      drive_cycle(1'b1, 1'b1);
      expV = scoreboard.pop_front();
      checks++;
      if (bus.out !== expV) begin
         errors++;
         $display("[TB] FAIL load_one out=%b expected=%b", bus.out, expV);
      end
      for (int i = 0; i < 5; i++) begin
         drive_cycle(i[0], 1'b0);
         expV = scoreboard.pop_front();
         checks++;
         if (bus.out !== expV) begin
            errors++;
            $display("[TB] FAIL hold[%0d] out=%b expected=%b", i, bus.out, expV);
         end
      end
      drive_cycle(1'b0, 1'b1);
      expV = scoreboard.pop_front();
      checks++;
      if (bus.out !== expV) begin
         errors++;
         $display("[TB] FAIL load_zero out=%b expected=%b", bus.out, expV);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] pattern;
      pattern = 5'b01101;
      for (int i = 0; i < 5; i++) begin
         drive_cycle(pattern[4 - i], 1'b1);
         expV = scoreboard.pop_front();
         checks++;
         if (bus.out !== expV) begin
            errors++;
            $display("[TB] FAIL back_to_back[%0d] out=%b expected=%b", i, bus.out, expV);
         end
      end
   endtask

   task automatic test_async_reset();
      drive_cycle(1'b1, 1'b1);
      expV = scoreboard.pop_front();
      checks++;
      if (bus.out !== expV) begin
         errors++;
         $display("[TB] FAIL async_preload out=%b expected=%b", bus.out, expV);
      end
      bus.load = 1'b0;
      rst_n    = 1'b0;
      expModel = 1'b0;
      #1;
      checks++;
      if (bus.out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_immediate out=%b expected=0", bus.out);
      end
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive_cycle(1'b1, 1'b0);
         expV = scoreboard.pop_front();
         checks++;
         if (bus.out !== expV) begin
            errors++;
            $display("[TB] FAIL async_after[%0d] out=%b expected=%b", i, bus.out, expV);
         end
      end
   endtask

   task automatic test_random();
      int randErrors;
      randErrors = 0;
      for (int i = 0; i < 1000; i++) begin
         drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         expV = scoreboard.pop_front();
         checks++;
         if (bus.out !== expV) begin
            errors++;
            randErrors++;
            if (randErrors <= 10) begin
               $display("[TB] FAIL random[%0d] out=%b expected=%b", i, bus.out, expV);
            end
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_load_hold();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
